// File: rtl/uart_rx_pkt_parser.sv
// Frame parser behind a UART receiver: hunts SYNC, takes LEN, buffers the payload,
// verifies a zero-sum checksum and replays the payload as a valid/ready byte stream.
module uart_rx_pkt_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 416_667
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_err,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       pkt_ok,
    output logic       chk_err,
    output logic       frame_err,
    output logic       tmo_err,
    output logic       ovr_err
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    wptr_q, wptr_d;
    logic [7:0]    rptr_q, rptr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          out_valid_q, out_valid_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic          chk_err_q, chk_err_d;
    logic          frame_err_q, frame_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          ovr_err_q, ovr_err_d;
    logic          wr_en;

    logic [7:0] mem_q [MAX_LEN];
    logic [7:0] rd_data_q;

    // rx_err takes priority over a coincident rx_done everywhere
    logic byte_ok;
    logic tmo_hit;
    assign byte_ok = rx_done && !rx_err;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        tmo_d       = '0;
        out_valid_d = out_valid_q;
        pkt_ok_d    = 1'b0;
        chk_err_d   = 1'b0;
        frame_err_d = 1'b0;
        tmo_err_d   = 1'b0;
        ovr_err_d   = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (byte_ok && rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_err) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_done) begin
                    if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                        len_d   = rx_data;
                        sum_d   = rx_data;
                        wptr_d  = 8'd0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_PAYLOAD: begin
                if (rx_err) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_done) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 8'd1;
                    sum_d  = sum_q + rx_data;
                    if (wptr_q + 8'd1 == len_q) begin
                        state_d = ST_CHK;
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CHK: begin
                if (rx_err) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_done) begin
                    if (sum_q + rx_data == 8'd0) begin
                        pkt_ok_d    = 1'b1;
                        rptr_d      = 8'd0;
                        out_valid_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    state_d   = ST_HUNT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_DRAIN: begin
                if (byte_ok) begin
                    ovr_err_d = 1'b1;
                end
                if (out_valid_q && out_ready) begin
                    if (rptr_q == len_q - 8'd1) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_HUNT;
                    end else begin
                        rptr_d = rptr_q + 8'd1;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_HUNT;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wptr_q      <= 8'd0;
            rptr_q      <= 8'd0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            pkt_ok_q    <= 1'b0;
            chk_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            pkt_ok_q    <= pkt_ok_d;
            chk_err_q   <= chk_err_d;
            frame_err_q <= frame_err_d;
            tmo_err_q   <= tmo_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    // Read address follows the next read pointer so the registered read is ready with out_valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= rx_data;
        end
        rd_data_q <= mem_q[rptr_d[AW-1:0]];
    end

    assign out_data  = out_valid_q ? rd_data_q : 8'h00;
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q && (rptr_q == len_q - 8'd1);
    assign pkt_ok    = pkt_ok_q;
    assign chk_err   = chk_err_q;
    assign frame_err = frame_err_q;
    assign tmo_err   = tmo_err_q;
    assign ovr_err   = ovr_err_q;

endmodule
